// File: rtl/data_mem_if.sv
// data_mem_if: valid/ready load/store request and response channels between initiator and data memory
interface data_mem_if #(
    parameter int DATA_W = 16
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [15:0]       req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/data_mem_responder.sv
// data_mem_responder: single-outstanding word memory responder with programmable wait states and range errors
module data_mem_responder #(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 3,
    parameter int WAIT_CYCLES = 2
) (
    input logic        clk,
    input logic        rst_n,
    data_mem_if.slave  bus
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              wr_q, wr_d;
    logic [15:0]       addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];

    logic              acc;
    logic              acc_write;
    logic [15:0]       acc_addr;
    logic [DATA_W-1:0] acc_wdata;
    logic              acc_err;
    logic [ADDR_W-1:0] acc_idx;

    assign bus.req_ready = (state_q == ST_IDLE);
    assign bus.rsp_valid = (state_q == ST_RESP);
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;

    // Next-state logic: capture in IDLE, count down in WAIT, perform the access once, hold until consumed
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wr_d      = wr_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        mem_d     = mem_q;
        acc       = 1'b0;
        acc_write = wr_q;
        acc_addr  = addr_q;
        acc_wdata = wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    wr_d    = bus.req_write;
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                    if (WAIT_CYCLES == 0) begin
                        // Zero wait states: the access uses the live request on the accepting edge
                        acc       = 1'b1;
                        acc_write = bus.req_write;
                        acc_addr  = bus.req_addr;
                        acc_wdata = bus.req_wdata;
                        state_d   = ST_RESP;
                    end else begin
                        cnt_d   = CNT_W'(WAIT_CYCLES - 1);
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    acc     = 1'b1;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    state_d = ST_IDLE;
                    rdata_d = '0;
                    err_d   = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        acc_err = |acc_addr[15:ADDR_W];
        acc_idx = acc_addr[ADDR_W-1:0];
        if (acc) begin
            err_d   = acc_err;
            rdata_d = (acc_write || acc_err) ? '0 : mem_q[acc_idx];
            if (acc_write && !acc_err) mem_d[acc_idx] = acc_wdata;
        end
    end

    // State and memory registers; reset drops any in-flight transaction and clears the store
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            mem_q   <= '{default: '0};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            mem_q   <= mem_d;
        end
    end
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: directed vector bench for two responders (2 and 0 wait states)
module tb_data_mem_responder;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    data_mem_if #(.DATA_W(16)) bus2 ();
    data_mem_if #(.DATA_W(16)) bus0 ();

    data_mem_responder #(.DATA_W(16), .ADDR_W(3), .WAIT_CYCLES(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .bus(bus2)
    );
    data_mem_responder #(.DATA_W(16), .ADDR_W(3), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0)
    );

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] rdata;
        logic        err;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // One full transaction on the 2-wait-state responder with rsp_ready held high
    task automatic txn2(input logic wr, input logic [15:0] addr, input logic [15:0] wdata,
                        input logic [15:0] exp_rdata, input logic exp_err, input string nm);
        int n;
        @(negedge clk);
        bus2.req_valid = 1'b1;
        bus2.req_write = wr;
        bus2.req_addr  = addr;
        bus2.req_wdata = wdata;
        bus2.rsp_ready = 1'b1;
        chk({nm, "_req_ready"}, bus2.req_ready, 1);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
            bus2.req_valid = 1'b0;
            bus2.req_addr  = ~addr;
            bus2.req_wdata = ~wdata;
        end while (!bus2.rsp_valid && n < 20);
        chk({nm, "_latency"}, n, 3);
        chk({nm, "_rdata"}, bus2.rsp_rdata, exp_rdata);
        chk({nm, "_err"}, bus2.rsp_err, exp_err);
        @(posedge clk);
        #1;
        chk({nm, "_clr"}, {bus2.rsp_valid, bus2.req_ready, bus2.rsp_err, bus2.rsp_rdata}, {3'b010, 16'h0});
    endtask

    initial begin
        int n;
        bus2.req_valid = 1'b0; bus2.req_write = 1'b0; bus2.req_addr = '0; bus2.req_wdata = '0; bus2.rsp_ready = 1'b0;
        bus0.req_valid = 1'b0; bus0.req_write = 1'b0; bus0.req_addr = '0; bus0.req_wdata = '0; bus0.rsp_ready = 1'b0;
        #1;
        chk("rst_out2", {bus2.req_ready, bus2.rsp_valid, bus2.rsp_err, bus2.rsp_rdata}, {3'b100, 16'h0});
        chk("rst_out0", {bus0.req_ready, bus0.rsp_valid, bus0.rsp_err, bus0.rsp_rdata}, {3'b100, 16'h0});
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int a = 0; a < 8; a++) vecs.push_back('{1'b0, 16'(a), 16'h0, 16'h0, 1'b0});
        vecs.push_back('{1'b1, 16'h0005, 16'hBEEF, 16'h0000, 1'b0});
        vecs.push_back('{1'b0, 16'h0005, 16'h0000, 16'hBEEF, 1'b0});
        vecs.push_back('{1'b0, 16'h0008, 16'h0000, 16'h0000, 1'b1});
        vecs.push_back('{1'b0, 16'hFFFF, 16'h0000, 16'h0000, 1'b1});
        vecs.push_back('{1'b1, 16'h0009, 16'h1234, 16'h0000, 1'b1});
        vecs.push_back('{1'b0, 16'h0001, 16'h0000, 16'h0000, 1'b0});
        vecs.push_back('{1'b1, 16'h0003, 16'h0F0F, 16'h0000, 1'b0});
        vecs.push_back('{1'b1, 16'h0100, 16'h7777, 16'h0000, 1'b1});
        vecs.push_back('{1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0});
        vecs.push_back('{1'b0, 16'h0003, 16'h0000, 16'h0F0F, 1'b0});
        vecs.push_back('{1'b0, 16'h0005, 16'h0000, 16'hBEEF, 1'b0});
        foreach (vecs[i])
            txn2(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].rdata, vecs[i].err, $sformatf("vec%0d", i));

        // Backpressure: load addr 5 held in RESP while a competing store is offered
        @(negedge clk);
        bus2.req_valid = 1'b1; bus2.req_write = 1'b0; bus2.req_addr = 16'h0005; bus2.rsp_ready = 1'b0;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
            bus2.req_write = 1'b1; bus2.req_wdata = 16'h1111;
        end while (!bus2.rsp_valid && n < 20);
        chk("bp_latency", n, 3);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            chk($sformatf("bp_hold%0d", c), {bus2.rsp_valid, bus2.req_ready, bus2.rsp_err, bus2.rsp_rdata}, {3'b100, 16'hBEEF});
        end
        @(negedge clk);
        bus2.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus2.req_valid = 1'b0;
        chk("bp_release", {bus2.rsp_valid, bus2.req_ready}, 2'b01);
        txn2(1'b0, 16'h0005, 16'h0, 16'hBEEF, 1'b0, "bp_noaccept");

        // Zero wait states: store then load back-to-back, two cycles per transaction
        @(negedge clk);
        bus0.rsp_ready = 1'b1;
        bus0.req_valid = 1'b1; bus0.req_write = 1'b1; bus0.req_addr = 16'h0007; bus0.req_wdata = 16'hA5A5;
        @(posedge clk);
        #1;
        chk("w0_store_rsp", {bus0.rsp_valid, bus0.req_ready, bus0.rsp_err, bus0.rsp_rdata}, {3'b100, 16'h0});
        bus0.req_write = 1'b0; bus0.req_wdata = 16'h0;
        @(posedge clk);
        #1;
        chk("w0_idle", {bus0.rsp_valid, bus0.req_ready}, 2'b01);
        @(posedge clk);
        #1;
        bus0.req_valid = 1'b0;
        chk("w0_load_rsp", {bus0.rsp_valid, bus0.rsp_err, bus0.rsp_rdata}, {2'b10, 16'hA5A5});
        @(posedge clk);
        #1;
        chk("w0_load_done", {bus0.rsp_valid, bus0.req_ready}, 2'b01);
        @(negedge clk);
        bus0.req_valid = 1'b1; bus0.req_addr = 16'h0008;
        @(posedge clk);
        #1;
        bus0.req_valid = 1'b0;
        chk("w0_err", {bus0.rsp_valid, bus0.rsp_err, bus0.rsp_rdata}, {2'b11, 16'h0});

        // Asynchronous reset in the middle of a store's wait period
        @(negedge clk);
        bus2.req_valid = 1'b1; bus2.req_write = 1'b1; bus2.req_addr = 16'h0002; bus2.req_wdata = 16'h5555;
        @(posedge clk);
        #1;
        bus2.req_valid = 1'b0;
        chk("rw_in_wait", {bus2.req_ready, bus2.rsp_valid}, 2'b00);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rw_async", {bus2.req_ready, bus2.rsp_valid, bus2.rsp_err, bus2.rsp_rdata}, {3'b100, 16'h0});
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        txn2(1'b0, 16'h0002, 16'h0, 16'h0000, 1'b0, "rw_load2");
        txn2(1'b0, 16'h0005, 16'h0, 16'h0000, 1'b0, "rw_load5");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
